// File: rtl/transfer_status_tx_pkg.sv
// Shared constants and state encoding for the transfer status transmitter.
// Status characters, packet size and the FSM states live here so the bench and RTL agree on names.
package transfer_status_tx_pkg;

  localparam logic [7:0]  CHAR_A     = 8'h41;
  localparam logic [7:0]  CHAR_K     = 8'h4B;
  localparam logic [7:0]  CHAR_START = 8'h31;
  localparam logic [7:0]  CHAR_STOP  = 8'h30;
  localparam logic [15:0] PKT_BYTES  = 16'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/transfer_status_tx.sv
// Sends an 8-byte "AK" status packet (flag char, sequence, frame count) to the UDP
// transmitter on every transfer_flag change and periodically as an idle heartbeat.
module transfer_status_tx
  import transfer_status_tx_pkg::*;
#(
  parameter int unsigned HEARTBEAT_CYCLES = 125_000_000,
  parameter int unsigned TIMEOUT_CYCLES   = 1_000_000,
  parameter logic [7:0]  START            = CHAR_START,
  parameter logic [7:0]  STOP             = CHAR_STOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        transfer_flag,
  input  logic        frame_done,
  input  logic        udp_tx_req,
  input  logic        udp_tx_done,
  output logic        udp_tx_start_en,
  output logic [31:0] udp_tx_data,
  output logic [15:0] udp_tx_byte_num,
  output logic        tx_busy
);

  // Handshake: udp_tx_start_en is a one-cycle pulse while in START; each one-cycle
  // udp_tx_req in SEND loads the next payload word into udp_tx_data on that edge;
  // udp_tx_done ends the packet. req/done outside SEND are ignored.

  tx_state_e   state, state_next;
  logic        flag_d;
  logic        pending;
  logic        flag_event;
  logic        hb_fire;
  logic        to_fire;
  logic [31:0] hb_cnt;
  logic [31:0] to_cnt;
  logic [31:0] frame_cnt;
  logic [31:0] word0, word1;
  logic [7:0]  seq;
  logic [1:0]  req_cnt;

  assign flag_event = (flag_d != transfer_flag);
  assign hb_fire    = (HEARTBEAT_CYCLES != 0) && (state == ST_IDLE) &&
                      (hb_cnt == HEARTBEAT_CYCLES - 1);
  assign to_fire    = (state == ST_SEND) && (to_cnt == TIMEOUT_CYCLES - 1);

  assign udp_tx_start_en = (state == ST_START);
  assign tx_busy         = (state == ST_START) || (state == ST_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pending) state_next = ST_START;
      ST_START: state_next = ST_SEND;
      ST_SEND:  if (udp_tx_done || to_fire) state_next = ST_GAP;
      ST_GAP:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_d          <= 1'b0;
      pending         <= 1'b0;
      hb_cnt          <= '0;
      to_cnt          <= '0;
      frame_cnt       <= '0;
      word0           <= '0;
      word1           <= '0;
      seq             <= '0;
      req_cnt         <= '0;
      udp_tx_data     <= '0;
      udp_tx_byte_num <= '0;
    end else begin
      flag_d <= transfer_flag;

      // New events win over the START clear so nothing arriving mid-packet is lost;
      // a timeout without done re-arms the packet for a retry.
      pending <= (pending && (state != ST_START)) || flag_event || hb_fire ||
                 (to_fire && !udp_tx_done);

      if (frame_done) frame_cnt <= frame_cnt + 32'd1;

      if (state == ST_START) begin
        hb_cnt <= '0;
      end else if (state == ST_IDLE && HEARTBEAT_CYCLES != 0) begin
        hb_cnt <= hb_fire ? 32'd0 : hb_cnt + 32'd1;
      end

      to_cnt <= (state == ST_SEND) ? to_cnt + 32'd1 : 32'd0;

      if (state == ST_IDLE && pending) udp_tx_byte_num <= PKT_BYTES;

      if (state == ST_START) begin
        word0   <= {CHAR_A, CHAR_K, (transfer_flag ? START : STOP), seq};
        word1   <= frame_cnt;
        seq     <= seq + 8'd1;
        req_cnt <= '0;
      end

      if (state == ST_SEND && udp_tx_req) begin
        case (req_cnt)
          2'd0: begin
            udp_tx_data <= word0;
            req_cnt     <= 2'd1;
          end
          2'd1: begin
            udp_tx_data <= word1;
            req_cnt     <= 2'd2;
          end
          default: udp_tx_data <= '0;
        endcase
      end
    end
  end

endmodule

// File: doc/transfer_status_tx.md
# transfer_status_tx

Transmit-side companion of the UDP command parser that sets the image `transfer_flag`. It sends an 8-byte status packet to the host through the UDP transmitter's word-request interface:
- immediately whenever `transfer_flag` changes;
- periodically as a heartbeat while idle.

The host thereby gets an acknowledgement of every start/stop command and a running frame count.

## Interface
Parameters:
- `HEARTBEAT_CYCLES`, default 125_000_000: clocks between heartbeat packets; 0 disables the heartbeat.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum clocks from start pulse to `udp_tx_done` before abort.
- `START`, default "1": status character sent when flag = 1.
- `STOP`, default "0": status character sent when flag = 0.

Ports:
- `clk` in, 1: single clock; all logic on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `transfer_flag` in, 1: current transfer state from the command parser.
- `frame_done` in, 1: one-cycle pulse per video frame transmitted.
- `udp_tx_req` in, 1: one-cycle pulse requesting the next 32-bit payload word.
- `udp_tx_done` in, 1: one-cycle pulse when the UDP packet has been fully sent.
- `udp_tx_start_en` out, 1: one-cycle pulse that starts a UDP packet.
- `udp_tx_data` out, 32: payload word; byte 0 is in bits [31:24].
- `udp_tx_byte_num` out, 16: payload byte count.
- `tx_busy` out, 1: high from the start pulse until the packet completes or aborts.

## Operation
- Packet, 8 bytes, MSB-first:
  - word0 = {8'h41 'A', 8'h4B 'K', flag_char, seq[7:0]}
  - word1 = frame_cnt[31:0]
- Field meanings:
  - `flag_char` = START or STOP, taken from `transfer_flag` as snapshotted in the START state.
  - `frame_cnt` is snapshotted in the START state.
- Edge detect: a registered copy `flag_d` of `transfer_flag`; `flag_d != transfer_flag` sets the `pending` bit.
- Heartbeat:
  - a counter runs only in IDLE and reloads whenever a packet starts;
  - reaching `HEARTBEAT_CYCLES-1` sets `pending`.
- `pending` is a single bit:
  - multiple events before a send collapse into one packet, which reports the flag value at send time;
  - `pending` is cleared in the START state.
- FSM:
  - IDLE → START when `pending`=1.
  - START, one cycle:
    - assert `udp_tx_start_en`, load `udp_tx_byte_num`=8, snapshot fields, increment `seq`;
    - → SEND.
  - SEND:
    - 1st `udp_tx_req` → drive word0; 2nd → word1; any later req → drive 32'h0;
    - `udp_tx_done` → GAP;
    - timeout counter reaching `TIMEOUT_CYCLES-1` → GAP with `pending` set, so the packet is retried.
  - GAP, one cycle → IDLE. This guarantees at least one idle clock between packets.
- Counters:
  - `seq` is 8-bit and wraps 255→0;
  - `frame_cnt` is 32-bit, increments on each `frame_done`, and wraps 2^32-1→0;
  - `frame_done` coinciding with the snapshot: the snapshot takes the pre-increment value.
- An event arriving while busy sets `pending` and is sent after GAP; it is never dropped.

## Timing
- Reset values:
  - `udp_tx_start_en`=0, `udp_tx_data`=0, `udp_tx_byte_num`=0, `tx_busy`=0;
  - FSM=IDLE, `pending`=0, `seq`=0, `frame_cnt`=0;
  - `flag_d`=0, so a flag already high at reset release produces one packet.
- Latency: for a flag change first sampled at edge N:
  - `pending`=1 after edge N;
  - START occupies cycle N+1→N+2 (`udp_tx_start_en` high after edge N+1).
- `udp_tx_data` is registered: valid on the edge following the `udp_tx_req` edge, and held until the next request.
- `udp_tx_byte_num` holds 8 from START until the next START; it is not cleared between packets.
- `tx_busy` is high in START and SEND, low in GAP and IDLE.
- Reset asserted mid-packet: all state returns to reset values at once; no `udp_tx_done` is awaited.
- `udp_tx_req` or `udp_tx_done` outside SEND is ignored.

## Structure
- Shared package:
  - status character constants ('A', 'K', START, STOP);
  - packet byte count (8);
  - FSM state encoding (IDLE, START, SEND, GAP).
- Single module with no sub-modules. The edge detector, heartbeat timer and timeout counter are small enough to stay inline.

## Test plan
- Reset release with `transfer_flag`=1 → one packet:
  - word0=32'h414B3100, word1=0;
  - `udp_tx_byte_num`=8; `udp_tx_start_en` a single-cycle pulse.
- Flag 1→0 with 3 prior `frame_done` pulses → word0=32'h414B3001, word1=32'd3.
- Flag toggles 0→1→0 while SEND is active → exactly one further packet after GAP, carrying '0'.
- `HEARTBEAT_CYCLES`=100 with no events → `udp_tx_start_en` every 100 idle cycles plus packet time; `seq` increments and wraps 255→0.
- Withhold `udp_tx_done` with `TIMEOUT_CYCLES`=50 → abort at cycle 50, GAP, then retry with `seq`+1.
- Third `udp_tx_req` in one packet → `udp_tx_data`=0. Reset asserted in SEND → all outputs 0 immediately.
